// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns a memory-stage access into one handshaked bus transaction,
// stalling the pipeline until it completes or times out.
module dmem_bus_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        flush_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, DRAIN = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d, err_q, err_d, we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic             launch, active, tmo, fin, cap;
  always_comb begin
    launch  = state_q == IDLE && mem_ce_i && !flush_i;
    active  = state_q == BUSY || state_q == DRAIN;
    tmo     = cnt_q == CNT_W'(TIMEOUT - 1);
    fin     = active && (bus_ack_i || tmo);
    // a flush that coincides with completion skips DRAIN and drops the result
    state_d = state_q == IDLE  ? (launch ? BUSY : IDLE) :
              state_q == BUSY  ? (fin ? (flush_i ? IDLE : DONE) : (flush_i ? DRAIN : BUSY)) :
              state_q == DRAIN ? (fin ? IDLE : DRAIN) : IDLE;
    cnt_d   = launch ? '0 : (active && !fin) ? cnt_q + 1'b1 : cnt_q;
    req_d   = state_d == BUSY || state_d == DRAIN;
    cap     = state_q == BUSY && fin && !flush_i;
    err_d   = cap && !bus_ack_i;
    data_d  = cap ? ((bus_ack_i && !we_q) ? bus_rdata_i : 32'h0) : data_q;
    we_d    = launch ? mem_we_i : we_q;
    sel_d   = launch ? mem_sel_i : sel_q;
    addr_d  = launch ? {mem_addr_i[31:2], 2'b00} : addr_q;
    wdata_d = launch ? mem_data_i : wdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end
  assign stallreq_o  = launch || active;
  assign bus_err_o   = err_q;
  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign mem_data_o  = data_q;
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: directed and randomized accesses checked against a
// transaction-level timeline model of the bridge.
module tb_dmem_bus_bridge;
  localparam int TO = 4;
  logic        clk = 1'b0, rst = 1'b0;
  logic        ce = 1'b0, we = 1'b0, flush = 1'b0, ack = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] addr = 32'h0, wd = 32'h0, rdata = 32'h0;
  logic [31:0] mdata, baddr, bwdata;
  logic        stall, err, breq, bwe;
  logic [3:0]  bsel;
  int          n_vec = 0, n_err = 0;
  logic [31:0] exp_data = 32'h0;

  dmem_bus_bridge #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .mem_ce_i(ce), .mem_we_i(we), .mem_sel_i(sel),
    .mem_addr_i(addr), .mem_data_i(wd), .flush_i(flush), .mem_data_o(mdata),
    .stallreq_o(stall), .bus_err_o(err), .bus_req_o(breq), .bus_we_o(bwe),
    .bus_sel_o(bsel), .bus_addr_o(baddr), .bus_wdata_o(bwdata),
    .bus_ack_i(ack), .bus_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // aw: BUSY/DRAIN cycle index carrying the ack (-1 = never); f: index carrying flush (-1 = none)
  task automatic access(input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input int aw, input int f);
    logic ok = aw >= 0 && aw < TO;
    int   n = ok ? aw + 1 : TO;
    @(posedge clk); #1;
    chk("idle_req", breq, 0);
    chk("idle_err", err, 0);
    chk("idle_data", mdata, exp_data);
    ce = 1; we = w; sel = s; addr = a; wd = d; flush = 0;
    ack = 1'($urandom_range(0, 1)); rdata = $urandom;
    #1 chk("idle_stall", stall, 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk("busy_req", breq, 1);
      chk("busy_addr", baddr, {a[31:2], 2'b00});
      chk("busy_we", bwe, w);
      chk("busy_sel", bsel, s);
      chk("busy_wdata", bwdata, d);
      ack = k == aw; rdata = rd; flush = k == f; ce = f < 0 || k < f;
      #1 chk("busy_stall", stall, 1);
    end
    @(posedge clk); #1;
    chk("end_req", breq, 0);
    if (f >= 0) begin
      chk("drain_err", err, 0);
      chk("drain_data", mdata, exp_data);
      ce = 0; ack = 0; flush = 0;
    end else begin
      exp_data = (ok && !w) ? rd : 32'h0;
      chk("done_err", err, !ok);
      chk("done_data", mdata, exp_data);
      ack = 1'($urandom_range(0, 1)); rdata = $urandom;
    end
    #1 chk("end_stall", stall, 0);
  endtask

  initial begin
    #1 rst = 1;
    #1;
    chk("rst_req", breq, 0);
    chk("rst_stall", stall, 0);
    chk("rst_err", err, 0);
    chk("rst_data", mdata, 0);
    chk("rst_addr", baddr, 0);
    chk("rst_bus", {bwe, bsel}, 0);
    chk("rst_wdata", bwdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    access(0, 4'b0011, 32'h8000_0006, 32'h0, 32'h1122_3344, 0, -1);
    access(1, 4'b1000, 32'h0000_0010, 32'hAAAA_AAAA, 32'h5555_5555, 4, -1);
    access(0, 4'b1111, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, -1, -1);
    access(0, 4'b1111, 32'h0000_0024, 32'h0, 32'hCAFE_F00D, 3, 1);
    access(0, 4'b1111, 32'h0000_0030, 32'h0, 32'h0BAD_C0DE, 1, -1);
    access(0, 4'b1100, 32'h0000_0032, 32'h0, 32'h1234_5678, 2, -1);
    access(0, 4'b1111, 32'h0000_0040, 32'h0, 32'h7777_7777, 0, 0);
    for (int i = 0; i < 40; i++) begin
      int aw = int'($urandom_range(0, 6)) - 1;
      int n = (aw >= 0 && aw < TO) ? aw + 1 : TO;
      int f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("gap_req", breq, 0);
        ce = 0; flush = 0; ack = 1'($urandom_range(0, 1)); rdata = $urandom;
        #1 chk("gap_stall", stall, 0);
      end
      access(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, $urandom, aw, f);
    end
    @(posedge clk); #1;
    ce = 1; we = 0; sel = 4'hF; addr = 32'h0000_0100; flush = 0; ack = 0;
    @(posedge clk); #1;
    chk("pre_rst_req", breq, 1);
    #2 rst = 1; ce = 0;
    #1;
    chk("arst_req", breq, 0);
    chk("arst_stall", stall, 0);
    chk("arst_data", mdata, 0);
    chk("arst_addr", baddr, 0);
    chk("arst_bus", {err, bwe, bsel}, 0);
    @(negedge clk) rst = 0; ack = 1; rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("stale_req", breq, 0);
    chk("stale_data", mdata, 0);
    chk("stale_err", err, 0);
    ack = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
